warp_id_queue: RTL and testbench



---
 rtl/warp_id_queue_pkg.sv | 10 +
 rtl/warp_id_queue_if.sv | 28 ++
 rtl/warp_id_queue_obuf.sv | 58 +++++
 rtl/warp_id_queue.sv | 102 ++++++++++
 tb/tb_warp_id_queue.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/warp_id_queue_pkg.sv
// Shared defaults and types for the warp-ID queue (1 core / 8 warps / 16 threads).
package warp_id_queue_pkg;

    localparam int unsigned WIQ_DEPTH = 8;
    localparam int unsigned WIQ_WIDTH = 3;
    localparam int unsigned WIQ_AW    = $clog2(WIQ_DEPTH);

    typedef logic [WIQ_WIDTH-1:0] warp_id_t;

endpackage

// File: rtl/warp_id_queue_if.sv
// Producer/consumer handshake bundle of the warp-ID queue.
interface warp_id_queue_if
    import warp_id_queue_pkg::*;
#(
    parameter int unsigned WIDTH = WIQ_WIDTH,
    parameter int unsigned AW    = WIQ_AW
) ();

    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [AW:0]      count;

    // master: the producer/consumer environment; slave: the queue
    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );

    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );

endinterface

// File: rtl/warp_id_queue_obuf.sv
// Two-entry in-order output buffer: pop the head, then append lane a, then lane b.
module warp_id_queue_obuf
    import warp_id_queue_pkg::*;
#(
    parameter int unsigned WIDTH = WIQ_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pop,
    input  logic             push_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic [1:0]       idx;

    // Caller keeps occupancy within two entries, so idx never exceeds 1 on a write
    always_comb begin
        slot_d = slot_q;
        idx    = cnt_q - 2'(pop);
        if (pop) begin
            slot_d[0] = slot_q[1];
        end
        if (push_a) begin
            slot_d[idx[0]] = data_a;
            idx            = idx + 2'd1;
        end
        if (push_b) begin
            slot_d[idx[0]] = data_b;
            idx            = idx + 2'd1;
        end
        cnt_d = idx;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: only slots below cnt_q are ever observed
    always_ff @(posedge clock) begin
        slot_q <= slot_d;
    end

    assign head = slot_q[0];
    assign cnt  = cnt_q;

endmodule

// File: rtl/warp_id_queue.sv
// Ready/valid warp-ID FIFO controlling an external 1R1W sync-read RAM,
// with a two-entry prefetch buffer hiding the one-cycle read latency.
module warp_id_queue
    import warp_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WIQ_DEPTH,
    parameter int unsigned WIDTH = WIQ_WIDTH,
    parameter int unsigned AW    = WIQ_AW
) (
    input  logic             clock,
    input  logic             reset_n,
    warp_id_queue_if.slave   io,
    output logic [AW-1:0]    mem_W0_addr,
    output logic             mem_W0_en,
    output logic [WIDTH-1:0] mem_W0_data,
    output logic [AW-1:0]    mem_R0_addr,
    output logic             mem_R0_en,
    input  logic [WIDTH-1:0] mem_R0_data
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    ram_cnt_q;
    logic [CW-1:0]    ram_cnt_d;
    logic [CW-1:0]    count_q;
    logic             inflight_q;

    logic [1:0]       buf_cnt;
    logic [WIDTH-1:0] buf_head;

    logic             enq_ready;
    logic             enq_fire;
    logic             deq_fire;
    logic [2:0]       room;
    logic             room_ok;
    logic             rd_issue;
    logic             bypass;
    logic             wr_en;

    // Handshake and RAM port decisions; room counts buffer slots free after this cycle's pop
    always_comb begin
        enq_ready = ram_cnt_q < CW'(DEPTH);
        deq_fire  = (buf_cnt != 2'd0) & io.deq_ready;
        enq_fire  = io.enq_valid & enq_ready;
        room      = 3'd2 - 3'(buf_cnt) - 3'(inflight_q) + 3'(deq_fire);
        room_ok   = room != 3'd0;
        rd_issue  = (ram_cnt_q != '0) & room_ok;
        bypass    = (ram_cnt_q == '0) & ~inflight_q & room_ok & enq_fire;
        wr_en     = enq_fire & ~bypass;
        ram_cnt_d = ram_cnt_q + CW'(wr_en) - CW'(rd_issue);
    end

    // Total held changes only through the external handshakes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_issue) begin
                rptr_q <= rptr_q + AW'(1);
            end
            ram_cnt_q  <= ram_cnt_d;
            count_q    <= count_q + CW'(enq_fire) - CW'(deq_fire);
            inflight_q <= rd_issue;
        end
    end

    // Captured read lands ahead of a bypassed entry; the two never coincide
    warp_id_queue_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clock   (clock),
        .reset_n (reset_n),
        .pop     (deq_fire),
        .push_a  (inflight_q),
        .data_a  (mem_R0_data),
        .push_b  (bypass),
        .data_b  (io.enq_bits),
        .head    (buf_head),
        .cnt     (buf_cnt)
    );

    assign io.enq_ready = enq_ready;
    assign io.deq_valid = buf_cnt != 2'd0;
    assign io.deq_bits  = buf_head;
    assign io.count     = count_q;

    assign mem_W0_en   = wr_en;
    assign mem_W0_addr = wptr_q;
    assign mem_W0_data = io.enq_bits;
    assign mem_R0_en   = rd_issue;
    assign mem_R0_addr = rptr_q;

endmodule

// File: tb/tb_warp_id_queue.sv
// Self-checking bench for warp_id_queue: directed corner cases plus a randomized
// run against a plain queue reference model, with a behavioural RAM macro.
module tb_warp_id_queue;
    import warp_id_queue_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    warp_id_queue_if io_if ();

    logic [WIQ_AW-1:0] mem_W0_addr;
    logic              mem_W0_en;
    warp_id_t          mem_W0_data;
    logic [WIQ_AW-1:0] mem_R0_addr;
    logic              mem_R0_en;
    warp_id_t          mem_R0_data;

    warp_id_queue dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .io          (io_if),
        .mem_W0_addr (mem_W0_addr),
        .mem_W0_en   (mem_W0_en),
        .mem_W0_data (mem_W0_data),
        .mem_R0_addr (mem_R0_addr),
        .mem_R0_en   (mem_R0_en),
        .mem_R0_data (mem_R0_data)
    );

    // 8x3 RAM macro: registered read, contents survive reset
    warp_id_t ram [WIQ_DEPTH];
    always_ff @(posedge clock) begin
        if (mem_W0_en) ram[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= ram[mem_R0_addr];
    end

    int       n_tests = 0;
    int       n_fail  = 0;
    warp_id_t model_q[$];
    logic     last_ef, last_df, last_wen, last_ren;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, update the model
    task automatic step(input logic ev, input int unsigned ed, input logic dr);
        logic ef, df;
        @(negedge clock);
        io_if.enq_valid = ev;
        io_if.enq_bits  = warp_id_t'(ed);
        io_if.deq_ready = dr;
        #1;
        chk("count", int'(io_if.count), model_q.size());
        if (model_q.size() == 0)  chk("empty_valid", int'(io_if.deq_valid), 0);
        if (model_q.size() <= 7)  chk("ready_room", int'(io_if.enq_ready), 1);
        if (model_q.size() >= 10) chk("ready_full", int'(io_if.enq_ready), 0);
        ef = ev & io_if.enq_ready;
        df = io_if.deq_valid & dr;
        if (df && model_q.size() != 0) chk("deq_bits", int'(io_if.deq_bits), int'(model_q.pop_front()));
        if (ef) model_q.push_back(warp_id_t'(ed));
        last_ef  = ef;
        last_df  = df;
        last_wen = mem_W0_en;
        last_ren = mem_R0_en;
    endtask

    initial begin
        int pe, pd;
        io_if.enq_valid = 1'b0;
        io_if.enq_bits  = '0;
        io_if.deq_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_valid", int'(io_if.deq_valid), 0);
        chk("rst_ready", int'(io_if.enq_ready), 1);
        chk("rst_count", int'(io_if.count), 0);
        chk("rst_wen", int'(mem_W0_en), 0);
        chk("rst_ren", int'(mem_R0_en), 0);

        // Single entry: bypass, visible next cycle, no RAM write
        step(1'b1, 5, 1'b0);
        chk("single_ef", int'(last_ef), 1);
        chk("single_wen", int'(last_wen), 0);
        step(1'b0, 0, 1'b0);
        chk("single_valid", int'(io_if.deq_valid), 1);
        chk("single_bits", int'(io_if.deq_bits), 5);
        chk("single_count", int'(io_if.count), 1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        // Fill to ten entries
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i % 8, 1'b0);
            chk("fill_accept", int'(last_ef), 1);
        end
        step(1'b0, 0, 1'b0);
        chk("fill_ready", int'(io_if.enq_ready), 0);
        chk("fill_count", int'(io_if.count), 10);

        // Full boundary: read issues, write refused this cycle, accepted the next
        step(1'b1, 6, 1'b1);
        chk("bnd_ef", int'(last_ef), 0);
        chk("bnd_wen", int'(last_wen), 0);
        chk("bnd_ren", int'(last_ren), 1);
        step(1'b1, 6, 1'b1);
        chk("bnd_ef2", int'(last_ef), 1);
        chk("bnd_wen2", int'(last_wen), 1);

        // Drain with no bubbles
        for (int i = 0; i < 20 && model_q.size() != 0; i++) begin
            step(1'b0, 0, 1'b1);
            chk("drain_df", int'(last_df), 1);
        end
        chk("drain_count", model_q.size(), 0);

        // Steady state at six held
        for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(0, 7), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, $urandom_range(0, 7), 1'b1);
            chk("steady_ef", int'(last_ef), 1);
            chk("steady_df", int'(last_df), 1);
        end
        step(1'b0, 0, 1'b0);
        chk("steady_count", int'(io_if.count), 6);

        // Reset with a read in flight
        step(1'b0, 0, 1'b1);
        chk("pre_rst_ren", int'(last_ren), 1);
        @(negedge clock);
        io_if.enq_valid = 1'b0;
        io_if.deq_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_q.delete();
        #1;
        chk("mid_rst_valid", int'(io_if.deq_valid), 0);
        chk("mid_rst_count", int'(io_if.count), 0);
        chk("mid_rst_ready", int'(io_if.enq_ready), 1);
        step(1'b1, 3, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("post_rst_valid", int'(io_if.deq_valid), 1);
        chk("post_rst_bits", int'(io_if.deq_bits), 3);

        // Randomized traffic with shifting bias
        pe = 50;
        pd = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pe = $urandom_range(10, 95);
                pd = $urandom_range(10, 95);
            end
            step($urandom_range(0, 99) < pe, $urandom_range(0, 7), $urandom_range(0, 99) < pd);
        end
        for (int i = 0; i < 30 && model_q.size() != 0; i++) step(1'b0, 0, 1'b1);
        chk("final_empty", model_q.size(), 0);
        step(1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
